// File: rtl/rv_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rv_pkg : shared RV32I front-end constants
// Revision: 1.0
// ----------------------------------------------------------------------------
package rv_pkg;
  localparam int          XLEN_DEFAULT = 32;
  localparam int          INST_W       = 32;
  localparam int          PC_STEP      = 4;
  localparam logic [31:0] NOP          = 32'h0000_0013;  // addi x0, x0, 0
endpackage
`default_nettype wire

// File: rtl/rv_fetch_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rv_fetch_fifo : circular instruction buffer with push/pop/clear and count
// Revision: 1.0
// ----------------------------------------------------------------------------
module rv_fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     clear,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int c_AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (c_AW+1)'(push) - (c_AW+1)'(pop);
    end
  end

  // Storage carries no reset; validity is tracked entirely by r_count.
  always_ff @(posedge clock) begin
    if (push && !clear) r_mem[r_wr_ptr] <= push_data;
  end

  assign head_data = r_mem[r_rd_ptr];
  assign count     = r_count;

endmodule
`default_nettype wire

// File: rtl/rv_fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rv_fetch_unit : pipelined RV32I fetch with credit-limited requests,
//                 instruction buffer and redirect-driven response dropping
// Revision: 1.0
// ----------------------------------------------------------------------------
module rv_fetch_unit
  import rv_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [XLEN-1:0]   inst_pc
);

  localparam int              c_CW    = $clog2(DEPTH) + 1;
  localparam logic [c_CW:0]   c_LIMIT = (c_CW+1)'(DEPTH);
  localparam logic [XLEN-1:0] c_STEP  = XLEN'(PC_STEP);

  logic [XLEN-1:0]        r_fetch_pc;
  logic [XLEN-1:0]        r_rsp_pc;
  logic [c_CW-1:0]        r_inflight;
  logic [c_CW-1:0]        r_drop_cnt;

  logic [c_CW-1:0]        w_count;
  logic [c_CW:0]          w_used;
  logic                   w_req_fire;
  logic                   w_rsp_ok;
  logic                   w_drop;
  logic                   w_push;
  logic                   w_pop;
  logic [XLEN-1:0]        w_redirect_pc;
  logic [XLEN+INST_W-1:0] w_head;

  // Buffered plus outstanding never exceeds DEPTH, so a response always has room.
  assign w_used         = {1'b0, r_inflight} + {1'b0, w_count};
  assign imem_req_valid = reset_n & ~redirect_valid & (w_used < c_LIMIT);
  assign imem_req_addr  = r_fetch_pc;

  assign w_req_fire    = imem_req_valid & imem_req_ready;
  assign w_rsp_ok      = imem_rsp_valid & (r_inflight != '0);
  assign w_drop        = w_rsp_ok & (r_drop_cnt != '0);
  assign w_push        = w_rsp_ok & (r_drop_cnt == '0) & ~redirect_valid;
  assign inst_valid    = (w_count != '0) & ~redirect_valid;
  assign w_pop         = inst_valid & inst_ready;
  assign w_redirect_pc = redirect_pc & ~XLEN'(3);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_pc <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_inflight <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_inflight <= r_inflight + c_CW'(w_req_fire) - c_CW'(w_rsp_ok);
      if (redirect_valid) begin
        // Every request still outstanding after this cycle belongs to the old path.
        r_fetch_pc <= w_redirect_pc;
        r_rsp_pc   <= w_redirect_pc;
        r_drop_cnt <= r_inflight - c_CW'(w_rsp_ok);
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + c_STEP;
        if (w_push)     r_rsp_pc   <= r_rsp_pc + c_STEP;
        if (w_drop)     r_drop_cnt <= r_drop_cnt - 1'b1;
      end
    end
  end

  rv_fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (XLEN + INST_W)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (w_push),
    .push_data ({r_rsp_pc, imem_rsp_data}),
    .pop       (w_pop),
    .clear     (redirect_valid),
    .head_data (w_head),
    .count     (w_count)
  );

  assign inst_pc   = w_head[XLEN+INST_W-1:INST_W];
  assign inst_data = w_head[INST_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_rv_fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_rv_fetch_unit : scenario tasks plus randomized traffic against a queue model
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_rv_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clock;
  logic        reset_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  rv_fetch_unit #(
    .XLEN     (32),
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct { logic [31:0] addr; bit stale; int due; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Model: requests the memory owes us, and instructions decode can see.
  pend_t       pend[$];
  ent_t        ibuf[$];
  logic [31:0] m_fetch_pc;
  int          last_due;

  bit          k_req_ready, k_inst_ready, k_redirect, k_spurious;
  int          k_lat;
  logic [31:0] k_redirect_pc;

  bit          exp_req_valid, exp_inst_valid;
  logic [31:0] exp_addr, exp_pc, exp_data;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a << 5) | 32'h13;
  endfunction

  task automatic model_reset();
    pend.delete();
    ibuf.delete();
    m_fetch_pc = RESET_PC;
    last_due   = 0;
  endtask

  task automatic set_knobs(input bit rdy, input int lat, input bit irdy);
    k_req_ready = rdy; k_lat = lat; k_inst_ready = irdy;
    k_redirect = 0; k_redirect_pc = '0; k_spurious = 0;
  endtask

  task automatic zero_inputs();
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
    redirect_valid = 0; redirect_pc = '0; inst_ready = 0;
  endtask

  task automatic reset_dut();
    @(negedge clock);
    reset_n = 0;
    zero_inputs();
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1;
  endtask

  // Apply this cycle's inputs (memory model responds in order) and form expectations.
  task automatic drive();
    @(negedge clock);
    imem_req_ready = k_req_ready;
    inst_ready     = k_inst_ready;
    redirect_valid = k_redirect;
    redirect_pc    = k_redirect_pc;
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1; imem_rsp_data = mem_word(pend[0].addr);
    end else begin
      imem_rsp_valid = (pend.size() == 0) && k_spurious;
      imem_rsp_data  = $urandom;
    end
    exp_req_valid  = !k_redirect && (pend.size() + ibuf.size() < DEPTH);
    exp_addr       = m_fetch_pc;
    exp_inst_valid = (ibuf.size() != 0) && !k_redirect;
    exp_pc   = (ibuf.size() != 0) ? ibuf[0].pc   : '0;
    exp_data = (ibuf.size() != 0) ? ibuf[0].data : '0;
    #1;
  endtask

  task automatic advance();
    pend_t e;
    int    due;
    if (exp_inst_valid && k_inst_ready) void'(ibuf.pop_front());
    if (imem_rsp_valid && pend.size() != 0) begin
      e = pend.pop_front();
      if (!e.stale && !k_redirect) ibuf.push_back('{e.addr, mem_word(e.addr)});
    end
    if (exp_req_valid && k_req_ready) begin
      due = (cyc + k_lat > last_due) ? cyc + k_lat : last_due;
      pend.push_back('{m_fetch_pc, 1'b0, due});
      last_due   = due;
      m_fetch_pc = m_fetch_pc + 32'd4;
    end
    if (k_redirect) begin
      foreach (pend[i]) pend[i].stale = 1'b1;
      ibuf.delete();
      m_fetch_pc = k_redirect_pc & ~32'h3;
    end
    @(posedge clock);
    cyc++;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset_n = 0;
    zero_inputs();
    model_reset();
    set_knobs(0, 1, 0);
    repeat (2) @(posedge clock);
    #1;
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rst_req_valid got %b want 0", imem_req_valid); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL rst_inst_valid got %b want 0", inst_valid); end
    n_cmp++; if (imem_req_addr !== RESET_PC) begin n_bad++; $display("FAIL rst_addr got %h want %h", imem_req_addr, RESET_PC); end
    @(negedge clock);
    reset_n = 1;
    drive();
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
      n_bad++; $display("FAIL rst_release_req got v=%b a=%h want v=1 a=%h", imem_req_valid, imem_req_addr, RESET_PC);
    end
    advance();
  endtask

  task automatic test_straight_line();
    int first_req = -1, first_iv = -1, n = 0;
    logic [31:0] want;
    reset_dut();
    set_knobs(1, 1, 1);
    for (int i = 0; i < 10; i++) begin
      drive();
      if (first_req < 0 && imem_req_valid && imem_req_ready) first_req = i;
      if (inst_valid) begin
        if (first_iv < 0) first_iv = i;
        want = n * 4;
        n_cmp++; if (inst_pc !== want || inst_data !== mem_word(want)) begin
          n_bad++; $display("FAIL sl_inst got pc=%h d=%h want pc=%h d=%h", inst_pc, inst_data, want, mem_word(want));
        end
        n_cmp++; if (i != first_iv + n) begin n_bad++; $display("FAIL sl_consecutive got cycle %0d want %0d", i, first_iv + n); end
        n++;
      end
      advance();
    end
    n_cmp++; if (first_req < 0 || first_iv - first_req != 2) begin
      n_bad++; $display("FAIL sl_latency got req@%0d iv@%0d want distance 2", first_req, first_iv);
    end
    n_cmp++; if (n != 8) begin n_bad++; $display("FAIL sl_delivered got %0d want 8", n); end
  endtask

  task automatic test_backpressure();
    int hs = 0;
    logic [31:0] want;
    reset_dut();
    set_knobs(1, 1, 0);
    for (int i = 0; i < 10; i++) begin
      drive();
      n_cmp++; if (imem_req_valid !== exp_req_valid) begin
        n_bad++; $display("FAIL bp_req_valid cyc=%0d got %b want %b", i, imem_req_valid, exp_req_valid);
      end
      if (imem_req_valid && imem_req_ready) begin
        want = hs * 4;
        n_cmp++; if (imem_req_addr !== want) begin n_bad++; $display("FAIL bp_addr got %h want %h", imem_req_addr, want); end
        hs++;
      end
      advance();
    end
    n_cmp++; if (hs != DEPTH) begin n_bad++; $display("FAIL bp_handshakes got %0d want %0d", hs, DEPTH); end
    drive();
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL bp_full got %b want 0", imem_req_valid); end
    advance();
    k_inst_ready = 1;
    drive();
    n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
      n_bad++; $display("FAIL bp_pop got v=%b pc=%h want v=1 pc=0", inst_valid, inst_pc);
    end
    advance();
    k_inst_ready = 0;
    drive();
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10) begin
      n_bad++; $display("FAIL bp_resume got v=%b a=%h want v=1 a=00000010", imem_req_valid, imem_req_addr);
    end
    advance();
  endtask

  task automatic test_mem_stall();
    reset_dut();
    set_knobs(0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      drive();
      n_cmp++; if ({imem_req_valid, imem_req_addr, inst_valid} !== {1'b1, RESET_PC, 1'b0}) begin
        n_bad++; $display("FAIL stall cyc=%0d got v=%b a=%h iv=%b want v=1 a=%h iv=0", i, imem_req_valid, imem_req_addr, inst_valid, RESET_PC);
      end
      advance();
    end
  endtask

  task automatic test_redirect();
    bit seen = 0, seen_hs = 0;
    reset_dut();
    set_knobs(1, 1, 0);
    drive(); advance();
    k_lat = 5;
    drive(); advance();
    drive(); advance();
    k_req_ready = 0; k_redirect = 1; k_redirect_pc = 32'h103;
    drive();
    n_cmp++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      n_bad++; $display("FAIL rd_cycle got req=%b iv=%b want 0 0", imem_req_valid, inst_valid);
    end
    advance();
    k_redirect = 0;
    drive();
    n_cmp++; if (inst_valid !== 1'b0 || imem_req_addr !== 32'h100) begin
      n_bad++; $display("FAIL rd_after got iv=%b a=%h want iv=0 a=00000100", inst_valid, imem_req_addr);
    end
    advance();
    k_req_ready = 1; k_lat = 1; k_inst_ready = 1;
    for (int i = 0; i < 20; i++) begin
      drive();
      if (!seen_hs && imem_req_valid) begin
        seen_hs = 1;
        n_cmp++; if (imem_req_addr !== 32'h100) begin n_bad++; $display("FAIL rd_first_req got %h want 00000100", imem_req_addr); end
      end
      n_cmp++; if (inst_valid !== exp_inst_valid || (exp_inst_valid && inst_pc !== exp_pc)) begin
        n_bad++; $display("FAIL rd_stream i=%0d got iv=%b pc=%h want iv=%b pc=%h", i, inst_valid, inst_pc, exp_inst_valid, exp_pc);
      end
      if (!seen && inst_valid) begin
        seen = 1;
        n_cmp++; if (inst_pc !== 32'h100) begin n_bad++; $display("FAIL rd_first_pc got %h want 00000100", inst_pc); end
      end
      advance();
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL rd_timeout got no delivery want pc 00000100"); end
  endtask

  task automatic test_redirect_rsp();
    bit seen = 0;
    reset_dut();
    set_knobs(1, 1, 1);
    drive(); advance();
    k_req_ready = 0; k_redirect = 1; k_redirect_pc = 32'h200;
    drive();
    n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL rr_cycle got iv=%b want 0", inst_valid); end
    advance();
    k_redirect = 0; k_req_ready = 1;
    for (int i = 0; i < 10; i++) begin
      drive();
      if (!seen && inst_valid) begin
        seen = 1;
        n_cmp++; if (inst_pc !== 32'h200 || inst_data !== mem_word(32'h200)) begin
          n_bad++; $display("FAIL rr_first got pc=%h d=%h want pc=00000200 d=%h", inst_pc, inst_data, mem_word(32'h200));
        end
      end
      advance();
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL rr_timeout got no delivery want pc 00000200"); end
  endtask

  task automatic test_reset_midstream();
    reset_dut();
    set_knobs(1, 1, 0);
    for (int i = 0; i < 3; i++) begin drive(); advance(); end
    k_lat = 20;
    drive(); advance();
    drive();
    n_cmp++; if (inst_valid !== 1'b1 || ibuf.size() != 3 || pend.size() != 1) begin
      n_bad++; $display("FAIL mr_setup got iv=%b buf=%0d pend=%0d want 1 3 1", inst_valid, ibuf.size(), pend.size());
    end
    #2;
    reset_n = 0;
    zero_inputs();
    #1;
    n_cmp++; if ({imem_req_valid, inst_valid, imem_req_addr} !== {1'b0, 1'b0, RESET_PC}) begin
      n_bad++; $display("FAIL mr_async got v=%b iv=%b a=%h want 0 0 %h", imem_req_valid, inst_valid, imem_req_addr, RESET_PC);
    end
    model_reset();
    @(negedge clock);
    reset_n = 1;
    set_knobs(1, 1, 1);
    drive();
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
      n_bad++; $display("FAIL mr_restart got v=%b a=%h want 1 %h", imem_req_valid, imem_req_addr, RESET_PC);
    end
    advance();
    for (int i = 0; i < 8; i++) begin
      drive();
      n_cmp++; if (inst_valid !== exp_inst_valid || (exp_inst_valid && inst_pc !== exp_pc)) begin
        n_bad++; $display("FAIL mr_stream i=%0d got iv=%b pc=%h want iv=%b pc=%h", i, inst_valid, inst_pc, exp_inst_valid, exp_pc);
      end
      advance();
    end
  endtask

  task automatic test_random();
    reset_dut();
    for (int i = 0; i < 800; i++) begin
      set_knobs($urandom_range(0, 9) < 7, $urandom_range(1, 4), $urandom_range(0, 9) < 6);
      k_spurious = $urandom_range(0, 9) == 0;
      k_redirect = $urandom_range(0, 19) == 0;
      k_redirect_pc = $urandom;
      if ($urandom_range(0, 3) == 0) k_redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      drive();
      n_cmp++; if (imem_req_valid !== exp_req_valid) begin
        n_bad++; $display("FAIL rnd_req_valid i=%0d got %b want %b", i, imem_req_valid, exp_req_valid);
      end
      n_cmp++; if (imem_req_addr !== exp_addr) begin
        n_bad++; $display("FAIL rnd_addr i=%0d got %h want %h", i, imem_req_addr, exp_addr);
      end
      n_cmp++; if (inst_valid !== exp_inst_valid) begin
        n_bad++; $display("FAIL rnd_inst_valid i=%0d got %b want %b", i, inst_valid, exp_inst_valid);
      end
      if (exp_inst_valid) begin
        n_cmp++; if ({inst_pc, inst_data} !== {exp_pc, exp_data}) begin
          n_bad++; $display("FAIL rnd_inst i=%0d got pc=%h d=%h want pc=%h d=%h", i, inst_pc, inst_data, exp_pc, exp_data);
        end
      end
      advance();
    end
  endtask

  initial begin
    reset_n = 0;
    zero_inputs();
    test_reset();
    test_straight_line();
    test_backpressure();
    test_mem_stall();
    test_redirect();
    test_redirect_rsp();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion want finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
